// File: rtl/timer_irq_ctrl.sv
// Programmable down-counting timer with prescaler, one-shot/periodic modes
// and a level interrupt. Four word-wide registers: CTRL, LOAD, COUNT, STATUS.
module timer_irq_ctrl #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       addr,
  input  logic [CNT_W-1:0] wr_data,
  output logic [CNT_W-1:0] rd_data,
  output logic             tick,
  output logic             irq
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPIRED
  } state_e;

  state_e state_q, state_d;

  // CTRL fields
  logic             en_q, en_d;
  logic             per_q, per_d;
  logic             irqen_q, irqen_d;
  logic [PSC_W-1:0] psc_q, psc_d;

  // Counting state
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PSC_W-1:0] pcnt_q, pcnt_d;
  logic             pend_q, pend_d;

  // Decoded write strobes and events
  logic wr_ctrl;
  logic wr_load;
  logic wr_stat;
  logic start;
  logic stop;
  logic at_zero;
  logic expire;

  assign wr_ctrl = wr_en && (addr == 2'd0);
  assign wr_load = wr_en && (addr == 2'd1);
  assign wr_stat = wr_en && (addr == 2'd3);
  assign start   = wr_ctrl && wr_data[0] && !en_q;
  assign stop    = wr_ctrl && !wr_data[0];
  assign at_zero = (count_q == '0);
  assign expire  = tick && at_zero;

  assign irq = pend_q && irqen_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enable edge restarts, disable idles, one-shot expiry parks
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        RUN: begin
          if (expire && !per_q) begin
            state_d = EXPIRED;
          end
        end
        IDLE:    state_d = IDLE;
        EXPIRED: state_d = EXPIRED;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: prescaled tick only while running
  always_comb begin
    tick = 1'b0;
    if (state_q == RUN) begin
      tick = (pcnt_q == psc_q);
    end
  end

  // Datapath next-state: register writes, prescaler, counter and pending flag
  always_comb begin
    en_d    = en_q;
    per_d   = per_q;
    irqen_d = irqen_q;
    psc_d   = psc_q;
    load_d  = load_q;
    count_d = count_q;
    pcnt_d  = pcnt_q;
    pend_d  = pend_q;

    if (wr_ctrl) begin
      en_d    = wr_data[0];
      per_d   = wr_data[1];
      irqen_d = wr_data[2];
      psc_d   = wr_data[8 +: PSC_W];
    end
    // A one-shot expiry drops enable even if a same-cycle CTRL write keeps it set
    if (expire && !per_q) begin
      en_d = 1'b0;
    end

    if (wr_load) begin
      load_d = wr_data;
    end

    // A disable write freezes COUNT and pending even if this cycle ticks
    if (start) begin
      count_d = load_q;
      pcnt_d  = '0;
    end else if (!stop) begin
      if (state_q == RUN) begin
        pcnt_d = tick ? '0 : pcnt_q + PSC_W'(1);
      end
      if (tick) begin
        if (!at_zero) begin
          count_d = count_q - CNT_W'(1);
        end else if (per_q) begin
          count_d = load_q;
        end
      end
    end

    // Set beats a same-cycle write-1 clear
    if (expire && !stop) begin
      pend_d = 1'b1;
    end else if (wr_stat && wr_data[0]) begin
      pend_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      per_q   <= 1'b0;
      irqen_q <= 1'b0;
      psc_q   <= '0;
      load_q  <= '0;
      count_q <= '0;
      pcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      en_q    <= en_d;
      per_q   <= per_d;
      irqen_q <= irqen_d;
      psc_q   <= psc_d;
      load_q  <= load_d;
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      pend_q  <= pend_d;
    end
  end

  // Register read mux; unused CTRL/STATUS bits read as zero
  always_comb begin
    rd_data = '0;
    unique case (addr)
      2'd0: begin
        rd_data[0]          = en_q;
        rd_data[1]          = per_q;
        rd_data[2]          = irqen_q;
        rd_data[8 +: PSC_W] = psc_q;
      end
      2'd1:    rd_data = load_q;
      2'd2:    rd_data = count_q;
      default: rd_data[0] = pend_q;
    endcase
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Self-checking bench for timer_irq_ctrl: behavioural model compared every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_timer_irq_ctrl;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned PSC_W = 8;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [1:0]       addr;
  logic [CNT_W-1:0] wr_data;
  logic [CNT_W-1:0] rd_data;
  logic             tick;
  logic             irq;

  timer_irq_ctrl #(.CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .tick    (tick),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [1:0]  ra = 2'd2;

  // Behavioural model: register contents plus a "running" flag
  logic             m_en, m_per, m_ien, m_pend, m_run;
  logic [PSC_W-1:0] m_psc, m_pre;
  logic [CNT_W-1:0] m_load, m_count;

  task automatic model_reset();
    m_en = 0; m_per = 0; m_ien = 0; m_pend = 0; m_run = 0;
    m_psc = '0; m_pre = '0; m_load = '0; m_count = '0;
  endtask

  task automatic model_step(input logic we, input logic [1:0] a, input logic [CNT_W-1:0] d);
    logic tk, zero, is_ctrl, starting, stopping, setp, clrp, old_per;
    logic [CNT_W-1:0] old_load;
    tk       = m_run && (m_pre == m_psc);
    zero     = (m_count == 0);
    is_ctrl  = we && (a == 2'd0);
    starting = is_ctrl && d[0] && !m_en;
    stopping = is_ctrl && !d[0];
    setp     = tk && zero && !stopping && !starting;
    clrp     = we && (a == 2'd3) && d[0];
    old_load = m_load;
    old_per  = m_per;
    if (starting) begin
      m_count = old_load; m_pre = '0; m_run = 1; m_en = 1;
    end else if (stopping) begin
      m_run = 0; m_en = 0;
    end else if (tk) begin
      m_pre = '0;
      if (!zero) m_count = m_count - 1;
      else if (old_per) m_count = old_load;
      else begin m_run = 0; m_en = 0; end
    end else if (m_run) begin
      m_pre = m_pre + 1;
    end
    if (is_ctrl) begin
      m_per = d[1]; m_ien = d[2]; m_psc = d[8 +: PSC_W];
    end
    if (we && (a == 2'd1)) m_load = d;
    if (setp) m_pend = 1;
    else if (clrp) m_pend = 0;
  endtask

  function automatic logic [CNT_W-1:0] model_rd(input logic [1:0] a);
    logic [CNT_W-1:0] v;
    v = '0;
    case (a)
      2'd0: begin v[0] = m_en; v[1] = m_per; v[2] = m_ien; v[8 +: PSC_W] = m_psc; end
      2'd1: v = m_load;
      2'd2: v = m_count;
      default: v[0] = m_pend;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock: drive a write at the edge, then read `ra` and compare with the model
  task automatic cyc(input logic we, input logic [1:0] a, input logic [CNT_W-1:0] d);
    wr_en = we; addr = a; wr_data = d;
    @(posedge clk);
    model_step(we, a, d);
    #1;
    wr_en = 0; addr = ra; wr_data = '0;
    @(negedge clk);
    chk("model_rd_data", rd_data, model_rd(ra));
    chk("model_tick", {31'd0, tick}, {31'd0, m_run && (m_pre == m_psc)});
    chk("model_irq", {31'd0, irq}, {31'd0, m_pend && m_ien});
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 2'd2, '0);
  endtask

  int unsigned exp_b_cnt [7] = '{2, 2, 1, 1, 0, 0, 2};
  int unsigned exp_b_tick[7] = '{0, 1, 0, 1, 0, 1, 0};
  int unsigned exp_d_cnt [6] = '{3, 2, 1, 0, 10, 9};

  initial begin
    rst_n = 0; wr_en = 0; addr = 2'd0; wr_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int unsigned r = 0; r < 4; r++) begin
      addr = 2'(r);
      #1 chk("reset_rd", rd_data, '0);
    end
    chk("reset_tick", {31'd0, tick}, '0);
    chk("reset_irq", {31'd0, irq}, '0);
    rst_n = 1;

    // One-shot, LOAD=3, prescale=0: 3,2,1,0 then expired
    ra = 2'd2;
    cyc(1, 2'd1, 32'd3);
    chk("A_count_before_enable", rd_data, 32'd0);
    cyc(1, 2'd0, 32'h1);
    chk("A_count0", rd_data, 32'd3);
    chk("A_tick0", {31'd0, tick}, 32'd1);
    idle(1); chk("A_count1", rd_data, 32'd2);
    idle(1); chk("A_count2", rd_data, 32'd1);
    idle(1); chk("A_count3", rd_data, 32'd0);
    chk("A_tick4", {31'd0, tick}, 32'd1);
    idle(1); chk("A_count_hold", rd_data, 32'd0);
    chk("A_no_tick_expired", {31'd0, tick}, 32'd0);
    ra = 2'd3; idle(1); chk("A_pending", rd_data, 32'd1);
    ra = 2'd0; idle(1); chk("A_ctrl_enable_cleared", rd_data, 32'd0);
    ra = 2'd3; cyc(1, 2'd3, 32'd1); chk("A_pending_cleared", rd_data, 32'd0);

    // Periodic, LOAD=2, prescale=1: tick every 2nd cycle, period 6
    ra = 2'd2;
    cyc(1, 2'd1, 32'd2);
    cyc(1, 2'd0, 32'h103);
    chk("B_count_n0", rd_data, exp_b_cnt[0]);
    chk("B_tick_n0", {31'd0, tick}, exp_b_tick[0]);
    for (int unsigned i = 1; i < 7; i++) begin
      idle(1);
      chk("B_count", rd_data, exp_b_cnt[i]);
      chk("B_tick", {31'd0, tick}, exp_b_tick[i]);
    end
    ra = 2'd3; idle(1); chk("B_pending", rd_data, 32'd1);
    ra = 2'd2; idle(12);

    // LOAD=0 periodic with irq: clear in same cycle as an expiry tick
    ra = 2'd3;
    cyc(1, 2'd0, 32'h0);
    cyc(1, 2'd3, 32'd1); chk("C_pending_clear", rd_data, 32'd0);
    cyc(1, 2'd1, 32'd0);
    cyc(1, 2'd0, 32'h7);
    chk("C_tick", {31'd0, tick}, 32'd1);
    idle(1); chk("C_pending_set", rd_data, 32'd1);
    cyc(1, 2'd3, 32'd1);
    chk("C_set_wins", rd_data, 32'd1);
    chk("C_irq_held", {31'd0, irq}, 32'd1);
    cyc(1, 2'd0, 32'h0);
    cyc(1, 2'd3, 32'd1);
    chk("C_cleared", rd_data, 32'd0);
    chk("C_irq_low", {31'd0, irq}, 32'd0);
    cyc(1, 2'd3, 32'd0); chk("C_write0_noop", rd_data, 32'd0);

    // LOAD rewritten mid-count takes effect only at the next reload
    ra = 2'd2;
    cyc(1, 2'd1, 32'd7);
    cyc(1, 2'd0, 32'h3); chk("D_count7", rd_data, 32'd7);
    idle(2); chk("D_count5", rd_data, 32'd5);
    cyc(1, 2'd1, 32'd10); chk("D_count4", rd_data, 32'd4);
    for (int unsigned i = 0; i < 6; i++) begin
      idle(1);
      chk("D_count", rd_data, exp_d_cnt[i]);
    end

    // Disable at COUNT=4 holds it; re-enable reloads from LOAD
    idle(5); chk("E_count4", rd_data, 32'd4);
    cyc(1, 2'd0, 32'h0); chk("E_hold_after_disable", rd_data, 32'd4);
    chk("E_no_tick", {31'd0, tick}, 32'd0);
    idle(3); chk("E_hold_idle", rd_data, 32'd4);
    cyc(1, 2'd0, 32'h7); chk("E_reload", rd_data, 32'd10);
    chk("E_irq", {31'd0, irq}, 32'd1);

    // Asynchronous reset at COUNT=7
    idle(3); chk("F_count7", rd_data, 32'd7);
    #2 rst_n = 0;
    #1;
    chk("F_rst_count", rd_data, 32'd0);
    chk("F_rst_tick", {31'd0, tick}, 32'd0);
    chk("F_rst_irq", {31'd0, irq}, 32'd0);
    model_reset();
    #1 rst_n = 1;
    idle(4);
    chk("F_count_after", rd_data, 32'd0);
    chk("F_tick_after", {31'd0, tick}, 32'd0);
    ra = 2'd3; idle(1); chk("F_pending_after", rd_data, 32'd0);

    // COUNT is read-only; CTRL reads zeros in unused bits
    ra = 2'd2; cyc(1, 2'd2, 32'h55); chk("G_count_ro", rd_data, 32'd0);
    ra = 2'd0; cyc(1, 2'd0, 32'hFFFF_FFF8); chk("G_ctrl_mask", rd_data, 32'h0000_FF00);
    cyc(1, 2'd0, 32'h0);

    // Enable write while enabled updates fields without reload
    ra = 2'd2;
    cyc(1, 2'd1, 32'd5);
    cyc(1, 2'd0, 32'h1); chk("H_count5", rd_data, 32'd5);
    idle(1); chk("H_count4", rd_data, 32'd4);
    cyc(1, 2'd0, 32'h5); chk("H_no_reload", rd_data, 32'd3);
    idle(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter CNT_W, default 32, SHALL set the width of the counter and load registers.
REQ-003 Parameter PSC_W, default 8, SHALL set the width of the prescale field and the prescale counter.
REQ-004 The block SHALL have the following ports:
- clk  input  1  core clock; all state changes on its rising edge
- rst_n  input  1  asynchronous reset, active low
- wr_en  input  1  register write strobe, one write per cycle
- addr  input  2  register select: 0 CTRL, 1 LOAD, 2 COUNT, 3 STATUS
- wr_data  input  CNT_W  write data
- rd_data  output  CNT_W  read data for addr, combinational from registers
- tick  output  1  one-cycle pulse on each prescaled count event
- irq  output  1  level interrupt, equal to pending AND irq_en

Function
REQ-005 CTRL SHALL hold the following fields, and SHALL read back with zeros in unused bits:
- bit0 enable
- bit1 periodic
- bit2 irq_en
- bits[8+PSC_W-1:8] prescale
REQ-006 LOAD SHALL be a read/write reload value; a write SHALL NOT alter COUNT until the next load or reload event.
REQ-007 COUNT SHALL be read-only; writes to addr 2 SHALL be ignored.
REQ-008 STATUS bit0 SHALL be the pending flag, cleared by writing 1 to it; writing 0 SHALL have no effect.
REQ-009 The FSM SHALL have three states: IDLE, RUN and EXPIRED.
REQ-010 In any state, a CTRL write with enable=1 while the current enable=0 SHALL, on the next cycle:
- load COUNT from LOAD
- clear the prescale counter
- enter RUN
REQ-011 A CTRL write with enable=0 SHALL enter IDLE on the next cycle; COUNT and pending SHALL hold their values.
REQ-012 A CTRL write with enable=1 while already enabled SHALL update periodic, irq_en and prescale only, with no reload.
REQ-013 In RUN, the prescale counter SHALL increment every cycle.
REQ-014 When the prescale counter equals prescale, tick SHALL be 1 for that cycle and the prescale counter SHALL return to 0.
REQ-015 With prescale=0, tick SHALL assert every cycle in RUN.
REQ-016 A tick in RUN with COUNT≠0 SHALL decrement COUNT by 1.
REQ-017 A tick in RUN with COUNT=0 SHALL set pending.
REQ-018 On a COUNT=0 tick with periodic=1, COUNT SHALL reload from LOAD and the FSM SHALL stay in RUN; the period SHALL be (LOAD+1)*(prescale+1) cycles.
REQ-019 On a COUNT=0 tick with periodic=0, the FSM SHALL enter EXPIRED and clear CTRL.enable; COUNT SHALL hold 0.
REQ-020 In IDLE and EXPIRED, tick SHALL be 0 and the prescale counter and COUNT SHALL hold.
REQ-021 If pending is set and write-1-cleared in the same cycle, set SHALL win.
REQ-022 With LOAD=0 and periodic=1, pending SHALL be set on every tick.
REQ-023 COUNT SHALL never wrap below 0; all arithmetic SHALL be unsigned, CNT_W bits.
REQ-024 Register writes SHALL take effect at the next rising clk edge; rd_data SHALL reflect the updated value in the following cycle.

Reset
REQ-025 While rst_n=0, independent of clk, the block SHALL clear the following to 0 and force the FSM to IDLE:
- CTRL, LOAD, COUNT
- prescale counter
- pending
- tick, irq
REQ-026 Reset asserted mid-count SHALL abort operation immediately; after release, no tick or irq SHALL occur until re-enabled.

Verification
REQ-027 The bench SHALL cover: LOAD=3, CTRL enable=1, periodic=0, prescale=0 -> COUNT reads 3,2,1,0 on consecutive cycles; pending=1 on the 4th tick; state EXPIRED; enable reads 0.
REQ-028 The bench SHALL cover: LOAD=2, periodic=1, prescale=1 -> tick every 2nd cycle; pending set every 6 cycles; COUNT sequence 2,1,0,2.
REQ-029 The bench SHALL cover: irq_en=1 with pending=1, then write STATUS=1 in the same cycle as an expiry tick -> pending stays 1 and irq stays 1.
REQ-030 The bench SHALL cover: write LOAD=10 while running with COUNT=5 -> count continues 4,3,...; reloads to 10 only after 0.
REQ-031 The bench SHALL cover: rst_n pulsed low asynchronously at COUNT=7 -> all outputs 0 immediately; COUNT reads 0 and no tick after release.
REQ-032 The bench SHALL cover: CTRL write enable=0 at COUNT=4, then enable=1 -> COUNT holds 4 while disabled, then reloads from LOAD.
